// File: rtl/zmod_link_checker.sv
// zmod_link_checker: checks a deserialised DDR data stream against an incrementing-counter
// or PRBS7 (x^7+x^6+1) reference and reports lock, per-word and per-lane errors, and
// saturating error and word counts gathered while locked.
//
// Ports:
//   rxclk      sole clock, rising edge
//   reset      asynchronous active-high reset
//   d_in_q     W = 2*LANES bit word; lane i on bits 2i (first) and 2i+1 (second)
//   d_valid    qualifies d_in_q; state holds while low
//   mode       0 = counter pattern, 1 = PRBS7, LSB first
//   clear      synchronous clear of err_count and word_count
//   locked     high while in the LOCKED state
//   error      one-cycle pulse per compared bad word
//   lane_err   per-lane mismatch flags of the last compared word
//   err_count  saturating count of bad words seen while locked
//   word_count saturating count of compared words seen while locked
module zmod_link_checker #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic [2*LANES-1:0] d_in_q,
  input  logic               d_valid,
  input  logic               mode,
  input  logic               clear,
  output logic               locked,
  output logic               error,
  output logic [LANES-1:0]   lane_err,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   word_count
);

  localparam int unsigned W      = 2 * LANES;
  localparam int unsigned MaxCnt = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned FcW    = $clog2(MaxCnt + 1);

  // Counter value that the next qualifying word turns into a state change.
  localparam logic [FcW-1:0] LockLast   = FcW'(LOCK_COUNT - 1);
  localparam logic [FcW-1:0] UnlockLast = FcW'(UNLOCK_COUNT - 1);

  localparam logic [0:0] StSearch = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic [W-1:0]     hist_q;
  logic             hist_vld_q;
  logic             mode_q;
  logic             mode_seen_q;
  logic             error_q;
  logic [LANES-1:0] lane_err_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             mode_chg;
  logic             compare;
  logic             bad;
  logic [W-1:0]     exp_word;
  logic [W-1:0]     exp_prbs;
  logic [W-1:0]     mismatch;
  logic [2*W-1:0]   stream;
  logic [LANES-1:0] lane_mis;

  // mode_seen_q suppresses a false mode change on the first cycle after reset.
  assign mode_chg = mode_seen_q && (mode != mode_q);
  assign compare  = d_valid && hist_vld_q && !mode_chg;

  // PRBS check is self-synchronising: each bit is predicted from received bits,
  // reaching back into the history word for the first seven.
  always_comb begin
    stream = {d_in_q, hist_q};
    for (int k = 0; k < int'(W); k++) begin
      exp_prbs[k] = stream[int'(W) + k - 7] ^ stream[int'(W) + k - 6];
    end
    exp_word = mode ? exp_prbs : (hist_q + W'(1));
    mismatch = d_in_q ^ exp_word;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_mis[i] = mismatch[2*i] | mismatch[2*i+1];
    end
    bad = |mismatch;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (mode_chg) begin
      state_d = StSearch;
      fcnt_d  = '0;
    end else if (compare) begin
      if (state_q == StSearch) begin
        if (bad) begin
          fcnt_d = '0;
        end else if (fcnt_q == LockLast) begin
          state_d = StLocked;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        if (!bad) begin
          fcnt_d = '0;
        end else if (fcnt_q == UnlockLast) begin
          state_d = StSearch;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (clear) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (compare && (state_q == StLocked)) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
      if (bad && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q     <= StSearch;
      fcnt_q      <= '0;
      hist_q      <= '0;
      hist_vld_q  <= 1'b0;
      mode_q      <= 1'b0;
      mode_seen_q <= 1'b0;
      error_q     <= 1'b0;
      lane_err_q  <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      mode_q      <= mode;
      mode_seen_q <= 1'b1;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      error_q     <= compare && bad;
      if (compare) lane_err_q <= lane_mis;
      if (mode_chg) begin
        hist_vld_q <= 1'b0;
      end else if (d_valid) begin
        hist_q     <= d_in_q;
        hist_vld_q <= 1'b1;
      end
    end
  end

  assign locked     = (state_q == StLocked);
  assign error      = error_q;
  assign lane_err   = lane_err_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_zmod_link_checker.sv
// Directed bench for zmod_link_checker (LANES=4, CNT_W=4 so saturation is reachable).
module tb_zmod_link_checker;

  logic       rxclk;
  logic       reset;
  logic [7:0] d_in_q;
  logic       d_valid;
  logic       mode;
  logic       clear;
  logic       locked;
  logic       error;
  logic [3:0] lane_err;
  logic [3:0] err_count;
  logic [3:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] sh;  // PRBS7 generator: sh[6] newest bit, sh[0] seven bits back

  zmod_link_checker #(
    .LANES       (4),
    .LOCK_COUNT  (16),
    .UNLOCK_COUNT(4),
    .CNT_W       (4)
  ) dut (
    .rxclk     (rxclk),
    .reset     (reset),
    .d_in_q    (d_in_q),
    .d_valid   (d_valid),
    .mode      (mode),
    .clear     (clear),
    .locked    (locked),
    .error     (error),
    .lane_err  (lane_err),
    .err_count (err_count),
    .word_count(word_count)
  );

  initial begin
    rxclk = 1'b0;
    forever #5 rxclk = ~rxclk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply one input word, let the edge sample it, settle just after.
  task automatic send(input logic [7:0] w, input logic v);
    d_in_q  = w;
    d_valid = v;
    @(posedge rxclk);
    #1;
  endtask

  // Serial PRBS7 model, LSB of the word first in the stream.
  task automatic gen_word(output logic [7:0] w);
    logic b;
    for (int k = 0; k < 8; k++) begin
      b    = sh[0] ^ sh[1];
      w[k] = b;
      sh   = {b, sh[6:1]};
    end
  endtask

  initial begin
    logic [7:0] w;
    int n_valid;
    int n_cmp;

    reset   = 1'b1;
    d_in_q  = '0;
    d_valid = 1'b0;
    mode    = 1'b0;
    clear   = 1'b0;
    sh      = 7'h5B;
    repeat (2) @(posedge rxclk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    check("rst_lane_err", lane_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_word_count", word_count, 0);
    reset = 1'b0;
    send(8'h00, 1'b0);

    // Counter pattern from F0: one history word then 16 good words to lock; wraps at word 17.
    for (int i = 0; i < 20; i++) begin
      send(8'(8'hF0 + i), 1'b1);
      check("cnt_error", error, 0);
      if (i == 15) check("cnt_not_locked_16", locked, 0);
      if (i == 16) check("cnt_locked_17", locked, 1);
    end
    check("cnt_word_count", word_count, 3);
    check("cnt_err_count", err_count, 0);

    // Bit 5 flipped on word 04 -> lane 2.
    send(8'h24, 1'b1);
    check("flip_error", error, 1);
    check("flip_lane_err", lane_err, 4'b0100);
    check("flip_err_count", err_count, 1);
    check("flip_word_count", word_count, 4);
    check("flip_locked", locked, 1);
    // History now holds the corrupted word, so the true next word also mismatches.
    send(8'h05, 1'b1);
    check("hist_error", error, 1);
    check("hist_err_count", err_count, 2);
    check("hist_locked", locked, 1);
    send(8'h06, 1'b1);
    check("good_error", error, 0);
    check("good_word_count", word_count, 6);

    // Four consecutive bad words unlock.
    for (int i = 0; i < 4; i++) begin
      send(8'h80, 1'b1);
      check("unl_error", error, 1);
      check("unl_locked", locked, (i < 3) ? 1 : 0);
    end
    check("unl_err_count", err_count, 6);
    check("unl_word_count", word_count, 10);
    send(8'h81, 1'b1);
    check("search_error", error, 0);
    check("search_word_count", word_count, 10);

    clear = 1'b1;
    send(8'h00, 1'b0);
    clear = 1'b0;
    check("clr_err_count", err_count, 0);
    check("clr_word_count", word_count, 0);

    // Relock: 0x81 already counted as one good word, 15 more needed.
    for (int i = 0; i < 15; i++) begin
      send(8'(8'h82 + i), 1'b1);
      if (i == 13) check("relock_not_yet", locked, 0);
    end
    check("relock", locked, 1);

    // Three isolated bad words while locked.
    send(8'h00, 1'b1);
    send(8'h01, 1'b1);
    send(8'h05, 1'b1);
    send(8'h06, 1'b1);
    send(8'h00, 1'b1);
    send(8'h01, 1'b1);
    check("err3_err_count", err_count, 3);
    check("err3_word_count", word_count, 6);
    check("err3_locked", locked, 1);

    // Clear coinciding with a bad word (expected 02, got 10).
    clear = 1'b1;
    send(8'h10, 1'b1);
    clear = 1'b0;
    check("clrbad_error", error, 1);
    check("clrbad_lane_err", lane_err, 4'b0101);
    check("clrbad_err_count", err_count, 0);
    check("clrbad_word_count", word_count, 0);
    check("clrbad_locked", locked, 1);

    // Mode change drops lock; next valid word only reloads history.
    mode = 1'b1;
    send(8'h00, 1'b0);
    check("mchg_locked", locked, 0);
    check("mchg_error", error, 0);

    n_valid = 0;
    n_cmp   = 0;
    for (int c = 0; c < 300 && n_cmp < 24; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_word(w);
        send(w, 1'b1);
        n_valid++;
      end else begin
        send(8'($urandom), 1'b0);
      end
      n_cmp = (n_valid > 0) ? n_valid - 1 : 0;
      check("prbs_error", error, 0);
      check("prbs_locked", locked, (n_cmp >= 16) ? 1 : 0);
      check("prbs_word_count", word_count, (n_cmp > 16) ? n_cmp - 16 : 0);
    end
    check("prbs_enough_words", (n_cmp >= 24) ? 1 : 0, 1);
    check("prbs_err_count", err_count, 0);

    // Reset mid-lock acts immediately.
    @(posedge rxclk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_err_count", err_count, 0);
    check("arst_word_count", word_count, 0);
    @(posedge rxclk);
    #1;
    reset = 1'b0;

    // After reset the first valid word is history only; lock after 17 words.
    for (int i = 0; i < 17; i++) begin
      gen_word(w);
      send(w, 1'b1);
      check("post_rst_error", error, 0);
      if (i == 15) check("post_rst_not_locked", locked, 0);
    end
    check("post_rst_locked", locked, 1);

    // word_count saturates at 15 with CNT_W=4.
    for (int i = 0; i < 20; i++) begin
      gen_word(w);
      send(w, 1'b1);
    end
    check("sat_word_count", word_count, 15);
    check("sat_err_count", err_count, 0);
    check("sat_locked", locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
